dft_gray_pipe: RTL and testbench
================================

# dft_gray_pipe

Two-stage registered 5-bit datapath that outputs the Gray-code encoding of its input. Built for testability: both pipeline registers form a mux-D scan chain, and an on-chip LFSR/MISR BIST engine can exercise the datapath and produce a pass/fail signature. It sits as a leaf block on the single reference clock domain and serves as the DFT demonstration core.

## Interface
Parameters: none (width fixed at 5).

Ports:
- refclk  in  1  sole clock; all flops update on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- data_in  in  5  functional input word
- data_out  out  5  functional output; equals stage-B register
- scan_en  in  1  1 = shift scan chain, overrides functional/BIST capture
- scan_in  in  1  serial scan input
- scan_out  out  1  serial scan output = B[4]
- bist_start  in  1  starts BIST when sampled high in IDLE or DONE
- bist_done  out  1  high while BIST is in DONE
- bist_sig  out  5  MISR signature register

## Operation
- Stage A register (5b): captures data_in, or the LFSR value while BIST is in RUN.
- Stage B register (5b): captures gray(A) = A ^ (A >> 1).
- data_out = B. No combinational path from input to output.
- Scan, when scan_en=1 at an edge:
  - A and B shift as one 10-bit chain: scan_in→A[0]→A[1]→…→A[4]→B[0]→…→B[4]; scan_out = B[4].
  - BIST controller flops are not scanned.
  - A scan_en edge in RUN aborts BIST to IDLE: bist_done=0, bist_sig holds.
- BIST FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + bist_start=1 + scan_en=0 → RUN: cnt←0, lfsr←5'b00001, misr←0.
  - RUN, edge with cnt=k (k=0..32): A←lfsr, lfsr←{lfsr[3:0], lfsr[4]^lfsr[2]}, B←gray(A).
  - For k≥2: misr←{misr[3:0], misr[4]^misr[2]} ^ B, using the pre-edge B, i.e. gray(lfsr pattern k−2).
  - cnt increments each RUN edge. At the edge with k=32 the FSM goes to DONE; that edge's MISR update is included.
  - DONE holds misr and bist_done=1 until the next bist_start or reset.
- bist_sig = misr at all times.
- During RUN, data_in is ignored and data_out still shows B.

## Timing
- Reset, asynchronous on reset=0: A=0, B=0, lfsr=5'b00001, misr=0, cnt=0, state=IDLE.
  - Outputs during reset: data_out=0, scan_out=0, bist_done=0, bist_sig=0.
- Reset deassertion is synchronous to refclk in the surrounding system. The first functional capture is on the first rising edge with reset=1.
- Functional latency: data_in sampled at edge N appears as gray(data_in) on data_out after edge N+1 (2 cycles).
- Scan: a bit applied at scan_in reaches scan_out after 10 shift edges.
- BIST duration: 33 rising edges in RUN from the edge after start is sampled. bist_done rises after the 34th edge counted from the start-sampling edge.
- LFSR: period 31, never 0; 31 distinct patterns are applied at k=0..30.
- Reset mid-BIST returns to IDLE immediately.
- bist_start held high in RUN is ignored. bist_start sampled in DONE restarts BIST.

## Test plan
- Reset: assert reset=0 mid-run → data_out=0, bist_done=0, bist_sig=0, scan_out=0 immediately, without waiting for a clock edge.
- Functional: apply data_in 00001, 00100, 00011, 00111, 11111 on consecutive edges → data_out two edges later is 00001, 00110, 00010, 00100, 10000 respectively.
- Scan shift: scan_en=1, shift 10'b1011001110 serially → after 10 edges A/B hold the pattern; a further 10 shifts reproduce it on scan_out in order.
- Scan capture: load A=00111 by scan, 1 functional edge → B=00100; shift out and check.
- BIST: pulse bist_start → bist_done=1 exactly 34 edges later; bist_sig equals the reference-model signature and is identical on a second run.
- BIST abort: assert scan_en at k=10 → state IDLE, bist_done stays 0; a new bist_start then yields the same golden signature.

Source files
------------

// File: rtl/dft_gray_pipe.sv
// dft_gray_pipe: two-stage registered 5-bit Gray-code datapath with a
// 10-bit mux-D scan chain through both stages and an LFSR/MISR BIST engine.
// Stage A captures data_in (or the LFSR pattern while BIST runs); stage B
// captures gray(A). The BIST controller flops are not part of the scan chain.
module dft_gray_pipe (
  input  logic       refclk,
  input  logic       reset,
  input  logic [4:0] data_in,
  output logic [4:0] data_out,
  input  logic       scan_en,
  input  logic       scan_in,
  output logic       scan_out,
  input  logic       bist_start,
  output logic       bist_done,
  output logic [4:0] bist_sig
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bist_state_t;

  // Gray encoding of a 5-bit word.
  function automatic logic [4:0] gray5(input logic [4:0] v);
    return v ^ {1'b0, v[4:1]};
  endfunction

  // One shift of the 5-bit feedback register shared by the LFSR and the MISR.
  function automatic logic [4:0] fb_step(input logic [4:0] v);
    return {v[3:0], v[4] ^ v[2]};
  endfunction

  logic [4:0]  stage_a_r, stage_a_s;
  logic [4:0]  stage_b_r, stage_b_s;
  logic [4:0]  lfsr_r,    lfsr_s;
  logic [4:0]  misr_r,    misr_s;
  logic [5:0]  cnt_r,     cnt_s;
  bist_state_t state_r,   state_s;
  logic        done_r,    done_s;

  // Next-state logic: scan shift has priority, then BIST run, then functional capture.
  always_comb begin
    stage_a_s = stage_a_r;
    stage_b_s = stage_b_r;
    lfsr_s    = lfsr_r;
    misr_s    = misr_r;
    cnt_s     = cnt_r;
    state_s   = state_r;

    if (scan_en) begin
      // Chain order: scan_in -> A[0..4] -> B[0..4] -> scan_out.
      {stage_b_s, stage_a_s} = {stage_b_r[3:0], stage_a_r, scan_in};
      if (state_r == ST_RUN) begin
        state_s = ST_IDLE;
      end else begin
        state_s = state_r;
      end
    end else begin
      stage_b_s = gray5(stage_a_r);
      case (state_r)
        ST_RUN: begin
          stage_a_s = lfsr_r;
          lfsr_s    = fb_step(lfsr_r);
          cnt_s     = cnt_r + 6'd1;
          // B only holds a pattern-derived value from the third run edge on.
          if (cnt_r >= 6'd2) begin
            misr_s = fb_step(misr_r) ^ stage_b_r;
          end else begin
            misr_s = misr_r;
          end
          if (cnt_r == 6'd32) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_IDLE, ST_DONE: begin
          stage_a_s = data_in;
          if (bist_start) begin
            state_s = ST_RUN;
            cnt_s   = 6'd0;
            lfsr_s  = 5'b00001;
            misr_s  = 5'b00000;
          end else begin
            state_s = state_r;
          end
        end
        default: begin
          stage_a_s = data_in;
          state_s   = ST_IDLE;
        end
      endcase
    end

    done_s = (state_s == ST_DONE);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge refclk or negedge reset) begin
    if (!reset) begin
      stage_a_r <= 5'b00000;
      stage_b_r <= 5'b00000;
      lfsr_r    <= 5'b00001;
      misr_r    <= 5'b00000;
      cnt_r     <= 6'd0;
      state_r   <= ST_IDLE;
      done_r    <= 1'b0;
    end else begin
      stage_a_r <= stage_a_s;
      stage_b_r <= stage_b_s;
      lfsr_r    <= lfsr_s;
      misr_r    <= misr_s;
      cnt_r     <= cnt_s;
      state_r   <= state_s;
      done_r    <= done_s;
    end
  end

  assign data_out  = stage_b_r;
  assign scan_out  = stage_b_r[4];
  assign bist_done = done_r;
  assign bist_sig  = misr_r;

endmodule

// File: tb/tb_dft_gray_pipe.sv
// Self-checking bench for dft_gray_pipe: table-driven functional vectors plus
// hand-written scan, BIST, BIST-abort and asynchronous-reset sequences.
module tb_dft_gray_pipe;

  logic       refclk;
  logic       reset;
  logic [4:0] data_in;
  logic [4:0] data_out;
  logic       scan_en;
  logic       scan_in;
  logic       scan_out;
  logic       bist_start;
  logic       bist_done;
  logic [4:0] bist_sig;

  int n_checks = 0;
  int n_pass   = 0;

  dft_gray_pipe dut (
    .refclk     (refclk),
    .reset      (reset),
    .data_in    (data_in),
    .data_out   (data_out),
    .scan_en    (scan_en),
    .scan_in    (scan_in),
    .scan_out   (scan_out),
    .bist_start (bist_start),
    .bist_done  (bist_done),
    .bist_sig   (bist_sig)
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  typedef struct packed {
    logic [4:0] din;
    logic [4:0] exp;
  } func_vec_t;

  func_vec_t vecs [8];

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge refclk);
    #1;
  endtask

  // Shift w in MSB first; seen records scan_out before each shift edge.
  task automatic shift_word(input logic [9:0] w, output logic [9:0] seen);
    scan_en = 1'b1;
    for (int i = 9; i >= 0; i--) begin
      seen[i] = scan_out;
      scan_in = w[i];
      tick();
    end
    scan_en = 1'b0;
    scan_in = 1'b0;
  endtask

  // Reference signature after n MISR updates fed with gray(pattern 0..n-1).
  function automatic logic [4:0] model_sig(input int n);
    logic [4:0] m;
    logic [4:0] p;
    m = 5'b00000;
    p = 5'b00001;
    for (int j = 0; j < n; j++) begin
      m = {m[3:0], m[4] ^ m[2]} ^ (p ^ (p >> 1));
      p = {p[3:0], p[4] ^ p[2]};
    end
    return m;
  endfunction

  // Full BIST run; bist_start stays high for hold_edges RUN edges (must be ignored).
  task automatic run_bist(input string tag, input int hold_edges, input logic [4:0] golden);
    bist_start = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      bist_start = (i < hold_edges) ? 1'b1 : 1'b0;
      tick();
    end
    bist_start = 1'b0;
    check({tag, "_done_not_yet"}, {9'd0, bist_done}, 10'd0);
    tick();
    check({tag, "_done"}, {9'd0, bist_done}, 10'd1);
    check({tag, "_sig"}, {5'd0, bist_sig}, {5'd0, golden});
  endtask

  initial begin
    logic [9:0] seen;
    logic [9:0] pat;
    logic [4:0] golden;
    logic [4:0] partial;

    vecs[0] = '{din: 5'b00001, exp: 5'b00001};
    vecs[1] = '{din: 5'b00100, exp: 5'b00110};
    vecs[2] = '{din: 5'b00011, exp: 5'b00010};
    vecs[3] = '{din: 5'b00111, exp: 5'b00100};
    vecs[4] = '{din: 5'b11111, exp: 5'b10000};
    vecs[5] = '{din: 5'b10101, exp: 5'b11111};
    vecs[6] = '{din: 5'b01010, exp: 5'b01111};
    vecs[7] = '{din: 5'b00000, exp: 5'b00000};

    golden  = model_sig(31);
    partial = model_sig(8);

    reset      = 1'b0;
    data_in    = 5'b00000;
    scan_en    = 1'b0;
    scan_in    = 1'b0;
    bist_start = 1'b0;
    #2;
    check("por_data_out", {5'd0, data_out}, 10'd0);
    check("por_bist_done", {9'd0, bist_done}, 10'd0);
    check("por_bist_sig", {5'd0, bist_sig}, 10'd0);
    check("por_scan_out", {9'd0, scan_out}, 10'd0);
    tick();
    reset = 1'b1;

    // Functional pipeline: vector i appears on data_out after edge i+1.
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) data_in = vecs[i].din;
      tick();
      if (i >= 1) check($sformatf("func_vec%0d", i - 1), {5'd0, data_out}, {5'd0, vecs[i - 1].exp});
    end
    data_in = 5'b00000;
    tick();
    tick();

    // Scan load then unload of a 10-bit pattern.
    pat = 10'b1011001110;
    shift_word(pat, seen);
    check("scan_load_B", {5'd0, data_out}, {5'd0, pat[9:5]});
    check("scan_load_so", {9'd0, scan_out}, {9'd0, pat[9]});
    shift_word(10'd0, seen);
    check("scan_unload", seen, pat);

    // Scan capture: A=00111 by scan, one functional edge, B=gray(A).
    pat = {5'b00000, 5'b00111};
    shift_word(pat, seen);
    data_in = 5'b00000;
    tick();
    check("capture_B", {5'd0, data_out}, 10'b00000_00100);
    shift_word(10'd0, seen);
    check("capture_unload", seen, 10'b00100_00000);

    // BIST twice; second run starts from DONE.
    run_bist("bist1", 0, golden);
    run_bist("bist2", 0, golden);

    // BIST abort by scan_en at k=10.
    bist_start = 1'b1;
    tick();
    bist_start = 1'b0;
    repeat (10) tick();
    scan_en = 1'b1;
    tick();
    scan_en = 1'b0;
    check("abort_done", {9'd0, bist_done}, 10'd0);
    check("abort_sig_hold", {5'd0, bist_sig}, {5'd0, partial});
    repeat (40) tick();
    check("abort_idle_done", {9'd0, bist_done}, 10'd0);
    check("abort_idle_sig", {5'd0, bist_sig}, {5'd0, partial});
    run_bist("bist_retry", 5, golden);

    // Asynchronous reset from a non-zero state.
    data_in = 5'b10101;
    tick();
    tick();
    check("pre_rst_data", {5'd0, data_out}, 10'b00000_11111);
    check("pre_rst_so", {9'd0, scan_out}, 10'd1);
    check("pre_rst_done", {9'd0, bist_done}, 10'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_data_out", {5'd0, data_out}, 10'd0);
    check("rst_bist_done", {9'd0, bist_done}, 10'd0);
    check("rst_bist_sig", {5'd0, bist_sig}, 10'd0);
    check("rst_scan_out", {9'd0, scan_out}, 10'd0);
    tick();
    reset = 1'b1;
    data_in = 5'b00011;
    tick();
    tick();
    check("post_rst_func", {5'd0, data_out}, 10'b00000_00010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
